// File: rtl/key_event_if.sv
// Event stream between the key controller and the menu/UI logic.
//
// Handshake: the producer asserts evt_valid with evt_key/evt_code and keeps
// all three stable until a cycle in which evt_ready is also high; that cycle
// is the transfer. The producer may present a new event in the very next
// cycle. evt_ready has no effect while evt_valid is low. evt_overflow is a
// one-cycle pulse that does not take part in the handshake.
interface key_event_if #(
    parameter int KEY_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic [1:0]       evt_code;
    logic             evt_overflow;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_code,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_code,
        input  evt_overflow,
        output evt_ready
    );
endinterface

// File: rtl/key_event_ctrl.sv
// Multi-key debounce and event scheduler for front-panel buttons.
// A shared prescaler produces a sample tick; each key has a debounce counter
// and an IDLE/HELD/REPEAT state machine. Events are parked in a one-deep
// slot per key and a round-robin arbiter moves them onto the event stream.
// An event raised while its slot is empty and the output can load goes
// straight to the output register in the same cycle.
module key_event_ctrl #(
    parameter  int NKEYS        = 4,
    parameter  int TICK_DIV     = 256,
    parameter  int STABLE_TICKS = 4,
    parameter  int LONG_TICKS   = 64,
    parameter  int REPEAT_TICKS = 16,
    localparam int KEY_W        = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NKEYS-1:0]   key_raw,
    output logic [NKEYS-1:0]   key_state,
    output logic [2*NKEYS-1:0] o_dbg_fsm,
    key_event_if.master        evt
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int SW   = $clog2(STABLE_TICKS + 1);
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int KW1  = KEY_W + 1;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_fsm_t;

    // Synchronizer, prescaler and per-key state
    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    logic [PW-1:0]    r_presc;
    logic [NKEYS-1:0] r_key_state;
    logic [SW-1:0]    r_stable_cnt [NKEYS];
    logic [HW-1:0]    r_hold_cnt   [NKEYS];
    key_fsm_t         r_fsm        [NKEYS];

    // Pending slots and output stage
    logic [NKEYS-1:0] r_pend;
    logic [1:0]       r_pend_code  [NKEYS];
    logic [KEY_W-1:0] r_ptr;
    logic             r_evt_valid;
    logic [KEY_W-1:0] r_evt_key;
    logic [1:0]       r_evt_code;
    logic             r_ovf;

    logic             w_tick;
    logic [NKEYS-1:0] w_diff;
    logic [NKEYS-1:0] w_accept;
    logic [NKEYS-1:0] w_hold_hit;
    logic [NKEYS-1:0] w_raise;
    logic [1:0]       w_raise_code [NKEYS];
    logic [SW-1:0]    w_stable_inc [NKEYS];
    logic [HW-1:0]    w_hold_inc   [NKEYS];

    logic [NKEYS-1:0] w_cand;
    logic [1:0]       w_cand_code  [NKEYS];
    logic [NKEYS-1:0] w_rot;
    logic             w_found;
    logic [KEY_W-1:0] w_off;
    logic [KW1-1:0]   w_sum;
    logic [KEY_W-1:0] w_idx;
    logic             w_can_load;
    logic             w_grant;
    logic [NKEYS-1:0] w_grant_vec;
    logic [1:0]       w_grant_code;
    logic [NKEYS-1:0] w_ovf_vec;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    // Two-flop synchronizer on the raw keys and the free-running sample prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_presc <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    // Per-key tick decisions: debounce acceptance, hold expiry, and the event they raise
    always_comb begin
        w_diff     = '0;
        w_accept   = '0;
        w_hold_hit = '0;
        w_raise    = '0;
        for (int k = 0; k < NKEYS; k++) begin
            w_stable_inc[k] = r_stable_cnt[k] + 1'b1;
            w_hold_inc[k]   = r_hold_cnt[k] + 1'b1;
            w_diff[k]       = r_sync2[k] ^ r_key_state[k];
            w_accept[k]     = w_tick && w_diff[k] && (w_stable_inc[k] == SW'(STABLE_TICKS));
            if (r_fsm[k] == ST_HELD)
                w_hold_hit[k] = w_tick && (w_hold_inc[k] == HW'(LONG_TICKS));
            else if (r_fsm[k] == ST_REPEAT)
                w_hold_hit[k] = w_tick && (w_hold_inc[k] == HW'(REPEAT_TICKS));
            // A level change wins over a long/repeat due in the same tick
            w_raise[k] = w_accept[k] || w_hold_hit[k];
            if (w_accept[k])
                w_raise_code[k] = r_key_state[k] ? EVT_RELEASE : EVT_PRESS;
            else
                w_raise_code[k] = (r_fsm[k] == ST_HELD) ? EVT_LONG : EVT_REPEAT;
        end
    end

    // Debounce counters, debounced levels and the per-key hold/repeat FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_state <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                r_stable_cnt[k] <= '0;
                r_hold_cnt[k]   <= '0;
                r_fsm[k]        <= ST_IDLE;
            end
        end else if (w_tick) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (w_accept[k]) begin
                    r_key_state[k]  <= ~r_key_state[k];
                    r_stable_cnt[k] <= '0;
                    r_hold_cnt[k]   <= '0;
                    r_fsm[k]        <= r_key_state[k] ? ST_IDLE : ST_HELD;
                end else begin
                    r_stable_cnt[k] <= w_diff[k] ? w_stable_inc[k] : '0;
                    case (r_fsm[k])
                        ST_HELD: begin
                            if (w_hold_hit[k]) begin
                                r_hold_cnt[k] <= '0;
                                r_fsm[k]      <= ST_REPEAT;
                            end else begin
                                r_hold_cnt[k] <= w_hold_inc[k];
                            end
                        end
                        ST_REPEAT: begin
                            r_hold_cnt[k] <= w_hold_hit[k] ? '0 : w_hold_inc[k];
                        end
                        default: begin
                            r_hold_cnt[k] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Round-robin pick among parked events plus events raised this cycle into empty slots
    always_comb begin
        w_cand = r_pend | w_raise;
        for (int k = 0; k < NKEYS; k++)
            w_cand_code[k] = r_pend[k] ? r_pend_code[k] : w_raise_code[k];
        w_rot   = NKEYS'({w_cand, w_cand} >> r_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = KEY_W'(i);
            end
        end
        w_sum        = {1'b0, r_ptr} + {1'b0, w_off};
        w_idx        = (w_sum >= KW1'(NKEYS)) ? KEY_W'(w_sum - KW1'(NKEYS)) : KEY_W'(w_sum);
        w_can_load   = !r_evt_valid || evt.evt_ready;
        w_grant      = w_can_load && w_found;
        w_grant_vec  = '0;
        w_grant_code = EVT_PRESS;
        w_ovf_vec    = '0;
        for (int k = 0; k < NKEYS; k++) begin
            w_grant_vec[k] = w_grant && (w_idx == KEY_W'(k));
            if (w_grant && (w_idx == KEY_W'(k)))
                w_grant_code = w_cand_code[k];
            // An occupied slot that is not being granted loses either the old or the new event
            w_ovf_vec[k] = w_raise[k] && r_pend[k] && !(w_grant && (w_idx == KEY_W'(k)));
        end
    end

    // Pending slots, output register, arbitration pointer and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_key   <= '0;
            r_evt_code  <= '0;
            r_ovf       <= 1'b0;
            for (int k = 0; k < NKEYS; k++)
                r_pend_code[k] <= '0;
        end else begin
            r_ovf <= |w_ovf_vec;
            if (w_can_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_key  <= w_idx;
                    r_evt_code <= w_grant_code;
                    r_ptr      <= (w_idx == KEY_W'(NKEYS - 1)) ? '0 : w_idx + 1'b1;
                end
            end
            for (int k = 0; k < NKEYS; k++) begin
                if (w_grant_vec[k]) begin
                    // The granted slot hands over its old event and takes any new one
                    r_pend[k] <= r_pend[k] && w_raise[k];
                    if (r_pend[k] && w_raise[k])
                        r_pend_code[k] <= w_raise_code[k];
                end else if (w_raise[k] && (w_accept[k] || !r_pend[k])) begin
                    r_pend[k]      <= 1'b1;
                    r_pend_code[k] <= w_raise_code[k];
                end
            end
        end
    end

    // Flatten the per-key FSM states for observation
    always_comb begin
        o_dbg_fsm = '0;
        for (int k = 0; k < NKEYS; k++)
            o_dbg_fsm[2*k +: 2] = r_fsm[k];
    end

    assign key_state        = r_key_state;
    assign evt.evt_valid    = r_evt_valid;
    assign evt.evt_key      = r_evt_key;
    assign evt.evt_code     = r_evt_code;
    assign evt.evt_overflow = r_ovf;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with small timing parameters.
module tb_key_event_ctrl;

    localparam int NKEYS        = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 8;
    localparam int REPEAT_TICKS = 4;

    localparam logic [1:0] C_PRESS = 2'b00;
    localparam logic [1:0] C_REL   = 2'b01;
    localparam logic [1:0] C_LONG  = 2'b10;
    localparam logic [1:0] C_REP   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_raw = '0;
    logic [3:0] key_state;
    logic [7:0] dbg_fsm;

    key_event_if #(.KEY_W(2)) evt_bus ();

    key_event_ctrl #(
        .NKEYS        (NKEYS),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_state (key_state),
        .o_dbg_fsm (dbg_fsm),
        .evt       (evt_bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [3:0] exp_q[$];
    int         xfer_q[$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         ovf_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic int xat(input int i);
        return (i < xfer_q.size()) ? xfer_q[i] : -1000;
    endfunction

    task automatic push_evt(input logic [1:0] key, input logic [1:0] code);
        exp_q.push_back({key, code});
    endtask

    // Monitor: every transfer is compared against the head of the expected queue
    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (!rst && evt_bus.evt_valid === 1'b1 && evt_bus.evt_ready === 1'b1) begin
            xfer_q.push_back(cyc);
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL evt_unexpected: observed key %0d code %0d expected no event",
                       evt_bus.evt_key, evt_bus.evt_code);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("evt_key_code", 32'({evt_bus.evt_key, evt_bus.evt_code}), 32'(e));
            end
        end
        if (evt_bus.evt_overflow === 1'b1) ovf_cnt++;
    end

    // Driver helpers: inputs change 1 time unit after the rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (evt_bus.evt_valid !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(evt_bus.evt_valid), 32'd1);
    endtask

    task automatic wait_xfers(input string tag, input int target, input int budget);
        int k = 0;
        while (xfer_q.size() < target && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(xfer_q.size()), 32'(target));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || evt_bus.evt_valid === 1'b1) && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key_state"}, 32'(key_state), 32'd0);
        check({tag, "_valid"}, 32'(evt_bus.evt_valid), 32'd0);
        check({tag, "_key"}, 32'(evt_bus.evt_key), 32'd0);
        check({tag, "_code"}, 32'(evt_bus.evt_code), 32'd0);
        check({tag, "_ovf"}, 32'(evt_bus.evt_overflow), 32'd0);
        check({tag, "_fsm"}, 32'(dbg_fsm), 32'd0);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin : stim
        int t0;
        int base;
        int o0;

        evt_bus.evt_ready = 1'b1;
        rst = 1'b1;
        step(3);
        check_idle("reset");
        rst = 1'b0;
        step(2);

        // Clean press of key 1 held for 20 ticks
        t0   = cyc;
        base = xfer_q.size();
        push_evt(2'd1, C_PRESS);
        push_evt(2'd1, C_LONG);
        push_evt(2'd1, C_REP);
        push_evt(2'd1, C_REP);
        push_evt(2'd1, C_REL);
        key_raw[1] = 1'b1;
        wait_xfers("t1_press_seen", base + 1, 30);
        check("t1_key_state_hi", 32'(key_state), 32'h2);
        step(80 - (cyc - t0));
        key_raw[1] = 1'b0;
        wait_drain("t1_drain", 100);
        check("t1_key_state_lo", 32'(key_state), 32'h0);
        check_range("t1_press_latency", xat(base) - t0, 11, 14);
        check("t1_long_gap", 32'(xat(base + 1) - xat(base)), 32'd32);
        check("t1_rep1_gap", 32'(xat(base + 2) - xat(base + 1)), 32'd16);
        check("t1_rep2_gap", 32'(xat(base + 3) - xat(base + 2)), 32'd16);
        check("t1_release_gap", 32'(xat(base + 4) - xat(base + 3)), 32'd16);
        step(4);

        // Key 0 bounces with one-tick widths, then settles high
        key_raw[0] = 1'b1; step(4);
        key_raw[0] = 1'b0; step(4);
        key_raw[0] = 1'b1; step(4);
        key_raw[0] = 1'b0; step(4);
        t0   = cyc;
        base = xfer_q.size();
        push_evt(2'd0, C_PRESS);
        key_raw[0] = 1'b1;
        wait_xfers("t2_press_seen", base + 1, 30);
        check_range("t2_press_latency", xat(base) - t0, 11, 14);
        check("t2_key_state_hi", 32'(key_state), 32'h1);
        push_evt(2'd0, C_REL);
        key_raw[0] = 1'b0;
        wait_drain("t2_drain", 40);
        step(4);

        // Keys 0, 2, 3 together from a freshly reset pointer
        rst = 1'b1;
        step(1);
        check_idle("t3_reset");
        rst = 1'b0;
        step(2);
        base = xfer_q.size();
        push_evt(2'd0, C_PRESS);
        push_evt(2'd2, C_PRESS);
        push_evt(2'd3, C_PRESS);
        key_raw = 4'b1101;
        wait_xfers("t3_press_seen", base + 3, 40);
        check("t3_press_gap1", 32'(xat(base + 1) - xat(base)), 32'd1);
        check("t3_press_gap2", 32'(xat(base + 2) - xat(base + 1)), 32'd1);
        check("t3_key_state_hi", 32'(key_state), 32'hD);
        step(4);
        base = xfer_q.size();
        push_evt(2'd0, C_REL);
        push_evt(2'd2, C_REL);
        push_evt(2'd3, C_REL);
        key_raw = 4'b0000;
        wait_drain("t3_drain", 40);
        check("t3_rel_gap1", 32'(xat(base + 1) - xat(base)), 32'd1);
        check("t3_rel_gap2", 32'(xat(base + 2) - xat(base + 1)), 32'd1);
        step(4);

        // Stalled consumer: event held stable, then exactly one transfer
        evt_bus.evt_ready = 1'b0;
        push_evt(2'd1, C_PRESS);
        key_raw[1] = 1'b1;
        wait_valid("t4_valid", 30);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(evt_bus.evt_valid), 32'd1);
            check("t4_hold_evt", 32'({evt_bus.evt_key, evt_bus.evt_code}), 32'({2'd1, C_PRESS}));
            step(1);
        end
        base = xfer_q.size();
        evt_bus.evt_ready = 1'b1;
        step(1);
        evt_bus.evt_ready = 1'b0;
        check("t4_single_xfer", 32'(xfer_q.size() - base), 32'd1);
        check("t4_valid_drop", 32'(evt_bus.evt_valid), 32'd0);

        // Output busy with release(1); key 2 press is overwritten by its release
        push_evt(2'd1, C_REL);
        key_raw[1] = 1'b0;
        wait_valid("t5_rel1_valid", 30);
        o0 = ovf_cnt;
        key_raw[2] = 1'b1;
        step(20);
        push_evt(2'd2, C_REL);
        key_raw[2] = 1'b0;
        step(24);
        check("t5_overflow_pulses", 32'(ovf_cnt - o0), 32'd1);
        check("t5_stalled_evt", 32'({evt_bus.evt_key, evt_bus.evt_code}), 32'({2'd1, C_REL}));
        evt_bus.evt_ready = 1'b1;
        wait_drain("t5_drain", 20);
        check("t5_key_state_lo", 32'(key_state), 32'h0);
        step(4);

        // Reset while key 1 is repeating and an event is on the output
        base = xfer_q.size();
        push_evt(2'd1, C_PRESS);
        push_evt(2'd1, C_LONG);
        key_raw[1] = 1'b1;
        wait_xfers("t6_long_seen", base + 2, 80);
        evt_bus.evt_ready = 1'b0;
        wait_valid("t6_rep_valid", 30);
        check("t6_rep_evt", 32'({evt_bus.evt_key, evt_bus.evt_code}), 32'({2'd1, C_REP}));
        check("t6_fsm_repeat", 32'(dbg_fsm[3:2]), 32'd2);
        rst = 1'b1;
        step(1);
        check_idle("t6_reset");
        rst = 1'b0;
        evt_bus.evt_ready = 1'b1;
        t0   = cyc;
        base = xfer_q.size();
        push_evt(2'd1, C_PRESS);
        wait_xfers("t6_fresh_press", base + 1, 30);
        check("t6_fresh_latency", 32'(xat(base) - t0), 32'd12);
        check("t6_key_state_hi", 32'(key_state), 32'h2);
        push_evt(2'd1, C_REL);
        key_raw[1] = 1'b0;
        wait_drain("t6_drain", 30);
        step(8);

        check("overflow_total", 32'(ovf_cnt), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
